// File: rtl/wide_add_seq.sv
// Multi-cycle WIDTH-bit adder reusing one 16-bit carry-select slice, LSB slice first.
// Optional subtract support is enabled with the WADD_SUB_EN macro.
module wide_add_seq #(
   parameter int unsigned WIDTH = 64
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
`ifdef WADD_SUB_EN
   input  logic             sub,
`endif
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf,
   output logic             busy
);

   localparam int unsigned SLICE_W = 16;
   localparam int unsigned NSLICE  = WIDTH / SLICE_W;
   localparam int unsigned CNT_W   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(NSLICE - 1);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t state_q, state_d;
   logic   accept;

   logic [CNT_W-1:0]                cnt_q;
   logic                            carry_q;
   logic [NSLICE-1:0][SLICE_W-1:0]  a_q, b_q, sum_q;
   logic                            cin_q;
`ifdef WADD_SUB_EN
   logic                            sub_q;
`endif
   logic cout_q, ovf_q, out_valid_q, in_ready_q, busy_q;

   logic [SLICE_W-1:0] sa, sb, slice_s;
   logic               sc, slice_c, slice_v;
   logic [8:0]         lo, hi0, hi1, hi;

   // Operand slice selection and carry-select slice adder
   always_comb begin
      sa = a_q[cnt_q];
      sb = b_q[cnt_q];
      sc = (cnt_q == '0) ? cin_q : carry_q;
`ifdef WADD_SUB_EN
      if (sub_q) begin
         sb = ~sb;
         if (cnt_q == '0) sc = 1'b1;
      end
`endif
      lo      = {1'b0, sa[7:0]} + {1'b0, sb[7:0]} + 9'(sc);
      hi0     = {1'b0, sa[15:8]} + {1'b0, sb[15:8]};
      hi1     = hi0 + 9'd1;
      hi      = lo[8] ? hi1 : hi0;
      slice_s = {hi[7:0], lo[7:0]};
      slice_c = hi[8];
      // Signed overflow: operands agree in sign but the result does not
      slice_v = (sa[15] == sb[15]) && (slice_s[15] != sa[15]);
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      accept  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (in_valid && in_ready_q) begin
               accept  = 1'b1;
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            if (cnt_q == LAST) state_d = S_DONE;
         end
         S_DONE: begin
            if (out_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State, handshake flags and result datapath
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         carry_q     <= 1'b0;
         sum_q       <= '0;
         cout_q      <= 1'b0;
         ovf_q       <= 1'b0;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         in_ready_q  <= 1'b1;
      end else begin
         state_q     <= state_d;
         in_ready_q  <= (state_d == S_IDLE);
         busy_q      <= (state_d != S_IDLE);
         out_valid_q <= (state_d == S_DONE);
         if (accept) cnt_q <= '0;
         if (state_q == S_RUN) begin
            sum_q[cnt_q] <= slice_s;
            carry_q      <= slice_c;
            if (cnt_q == LAST) begin
               cnt_q  <= '0;
               cout_q <= slice_c;
               ovf_q  <= slice_v;
            end else begin
               cnt_q <= CNT_W'(cnt_q + 1'b1);
            end
         end
      end
   end

   // Operand capture on accept
   always_ff @(posedge clk) begin
      if (accept) begin
         a_q   <= a;
         b_q   <= b;
         cin_q <= cin;
`ifdef WADD_SUB_EN
         sub_q <= sub;
`endif
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign busy      = busy_q;
   assign sum       = sum_q;
   assign cout      = cout_q;
   assign ovf       = ovf_q;

endmodule

// File: tb/tb_wide_add_seq.sv
// Directed scoreboard bench for wide_add_seq (64-bit and 16-bit instances).
module tb_wide_add_seq;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf, busy;
   logic [63:0] a, b, sum;

   logic        in_valid16, in_ready16, out_valid16, cout16, ovf16, busy16;
   logic [15:0] a16, b16, sum16;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [63:0] s;
      logic        c;
      logic        v;
   } exp_t;

   exp_t sb_q[$];
   exp_t e_hold;

   always #5 clk = ~clk;

   wide_add_seq #(.WIDTH(64)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .cin(cin),
`ifdef WADD_SUB_EN
      .sub(sub),
`endif
      .out_valid(out_valid), .out_ready(out_ready), .sum(sum),
      .cout(cout), .ovf(ovf), .busy(busy)
   );

   wide_add_seq #(.WIDTH(16)) dut16 (
      .clk(clk), .rst(rst), .in_valid(in_valid16), .in_ready(in_ready16),
      .a(a16), .b(b16), .cin(1'b0),
`ifdef WADD_SUB_EN
      .sub(1'b0),
`endif
      .out_valid(out_valid16), .out_ready(1'b1), .sum(sum16),
      .cout(cout16), .ovf(ovf16), .busy(busy16)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic exp_t model(input logic [63:0] x, input logic [63:0] y,
                                  input logic ci, input logic sb);
      exp_t        r;
      logic [63:0] yy;
      logic [64:0] t;
      yy  = sb ? ~y : y;
      t   = {1'b0, x} + {1'b0, yy} + 65'(sb ? 1'b1 : ci);
      r.s = t[63:0];
      r.c = t[64];
      r.v = (x[63] == yy[63]) && (t[63] != x[63]);
      return r;
   endfunction

   task automatic start(input logic [63:0] x, input logic [63:0] y,
                        input logic ci, input logic sb);
      chk("in_ready_before_accept", 64'(in_ready), 64'd1);
      a = x; b = y; cin = ci; sub = sb; in_valid = 1'b1;
      sb_q.push_back(model(x, y, ci, sb));
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("busy_after_accept", 64'(busy), 64'd1);
   endtask

   task automatic wait_result(input string tag, input int lat, output exp_t e);
      int n = 0;
      while (!out_valid && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      chk({tag, "_latency"}, 64'(n), 64'(lat));
      e = '{s: 64'd0, c: 1'b0, v: 1'b0};
      if (sb_q.size() == 0) begin
         chk({tag, "_scoreboard_empty"}, 64'd0, 64'd1);
      end else begin
         e = sb_q.pop_front();
         chk({tag, "_sum"},  sum, e.s);
         chk({tag, "_cout"}, 64'(cout), 64'(e.c));
         chk({tag, "_ovf"},  64'(ovf), 64'(e.v));
      end
   endtask

   task automatic ack(input string tag);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk({tag, "_out_valid_cleared"}, 64'(out_valid), 64'd0);
      chk({tag, "_in_ready_back"},     64'(in_ready), 64'd1);
      chk({tag, "_busy_cleared"},      64'(busy), 64'd0);
   endtask

   task automatic run_op(input string tag, input logic [63:0] x, input logic [63:0] y,
                         input logic ci, input logic sb);
      exp_t e;
      start(x, y, ci, sb);
      wait_result(tag, 4, e);
      ack(tag);
   endtask

   initial begin
      exp_t e;
      int   n;
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
      in_valid16 = 1'b0; a16 = '0; b16 = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_in_ready",  64'(in_ready), 64'd1);
      chk("rst_busy",      64'(busy), 64'd0);
      chk("rst_sum",       sum, 64'd0);
      chk("rst_cout",      64'(cout), 64'd0);
      chk("rst_ovf",       64'(ovf), 64'd0);
      rst = 1'b0;
      @(posedge clk); #1;

      // Carry ripple across all slices, signed overflow, slice boundary, carry-in
      run_op("all_ones_plus1", 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0);
      run_op("max_pos_plus1",  64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0);
      run_op("slice_boundary", 64'h0000_0000_0000_FFFF, 64'd1, 1'b0, 1'b0);
      run_op("cin_only",       64'd0, 64'd0, 1'b1, 1'b0);
      run_op("mixed",          64'hDEAD_BEEF_0123_4567, 64'h8765_4321_FEDC_BA98, 1'b1, 1'b0);

      // Back-pressure: result held, new request ignored until acknowledged
      start(64'h0123_4567_89AB_CDEF, 64'h1111_1111_1111_1111, 1'b0, 1'b0);
      wait_result("bp", 4, e_hold);
      a = 64'hAAAA_0000_5555_FFFF; b = 64'h0000_FFFF_0000_0001; cin = 1'b1; in_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         chk("bp_out_valid_held", 64'(out_valid), 64'd1);
         chk("bp_in_ready_low",   64'(in_ready), 64'd0);
         chk("bp_sum_stable",     sum, e_hold.s);
         chk("bp_cout_stable",    64'(cout), 64'(e_hold.c));
      end
      in_valid = 1'b0;
      ack("bp");
      run_op("bp_next", 64'hAAAA_0000_5555_FFFF, 64'h0000_FFFF_0000_0001, 1'b1, 1'b0);

      // Reset two cycles into RUN aborts the operation
      start(64'hFFFF_0000_FFFF_0000, 64'h0001_0001_0001_0001, 1'b0, 1'b0);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      void'(sb_q.pop_back());
      chk("abort_out_valid", 64'(out_valid), 64'd0);
      chk("abort_in_ready",  64'(in_ready), 64'd1);
      chk("abort_busy",      64'(busy), 64'd0);
      chk("abort_sum",       sum, 64'd0);
      run_op("after_abort", 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0, 1'b0);
      chk("after_abort_literal", model(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321,
                                       1'b0, 1'b0).s, 64'h2222_2222_2222_2211);

`ifdef WADD_SUB_EN
      run_op("sub_neg",      64'd5, 64'd7, 1'b0, 1'b1);
      run_op("sub_ovf",      64'h8000_0000_0000_0000, 64'd1, 1'b0, 1'b1);
      run_op("sub_cin_ignr", 64'd100, 64'd40, 1'b1, 1'b1);
`endif

      // 16-bit instance: single-slice latency and overflow
      chk("w16_in_ready", 64'(in_ready16), 64'd1);
      a16 = 16'h8000; b16 = 16'h8000; in_valid16 = 1'b1;
      @(posedge clk); #1;
      in_valid16 = 1'b0;
      chk("w16_not_yet_valid", 64'(out_valid16), 64'd0);
      n = 0;
      while (!out_valid16 && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      chk("w16_latency", 64'(n), 64'd1);
      chk("w16_sum",     64'(sum16), 64'd0);
      chk("w16_cout",    64'(cout16), 64'd1);
      chk("w16_ovf",     64'(ovf16), 64'd1);
      @(posedge clk); #1;
      chk("w16_released", 64'(out_valid16), 64'd0);
      chk("w16_idle",     64'(busy16), 64'd0);

      chk("scoreboard_drained", 64'(sb_q.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/wide_add_seq.md
Name: wide_add_seq

Overview:
- Multi-cycle sequencer that performs a WIDTH-bit add by time-multiplexing one internal 16-bit carry-select adder slice.
- The slice is the team's existing 16-bit carry-select adder with carry-in, carry-out and signed overflow.
- Processes one 16-bit slice per cycle, LSB slice first, chaining the carry through a register.
- Sits between the ALU issue logic and wide-operand consumers; uses valid/ready handshakes on both sides.

Parameters:
- WIDTH, 64, operand/result width; must be a multiple of 16 and at least 16.
- NSLICE, WIDTH/16, derived slice count; local, not overridable.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  synchronous reset, active-high.
- in_valid  input  1  request valid.
- in_ready  output  1  block can accept; high only in IDLE.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry into slice 0.
- sub  input  1  subtract select; present only with WADD_SUB_EN.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- sum  output  WIDTH  result.
- cout  output  1  carry out of the top slice.
- ovf  output  1  signed overflow of the top slice.
- busy  output  1  high in RUN or DONE.

Behaviour:
- Reset (synchronous, active-high, wins over all other events):
  - state=IDLE, slice counter=0, carry register=0.
  - sum=0, cout=0, ovf=0, out_valid=0, busy=0, in_ready=1.
- State IDLE:
  - in_ready=1.
  - On in_valid&in_ready: latch a, b, cin (and sub) into operand registers, set counter=0, go to RUN.
- State RUN:
  - Slice adder inputs: latched a[16k+15:16k] and b slice for k=counter.
  - Slice 0 carry-in is the latched cin; later slices take the carry register.
  - Each edge: write the slice result into sum[16k+15:16k], carry register ← slice carry-out, counter++.
  - When counter==NSLICE-1, the edge also writes cout and ovf from that slice, sets out_valid=1, goes to DONE, and wraps the counter to 0.
  - Latency: out_valid rises exactly NSLICE cycles after the accept edge (4 for WIDTH=64, 1 for WIDTH=16).
- State DONE:
  - out_valid=1; sum, cout and ovf are held stable.
  - On out_ready: out_valid←0, go to IDLE. in_ready rises the cycle after, so there is no same-cycle re-accept.
- Handshake and input rules:
  - in_valid while busy is ignored and not queued.
  - Changes on a, b, cin or sub after accept have no effect.
  - out_ready outside DONE is ignored.
- Arithmetic:
  - Modulo 2^WIDTH.
  - cout is the unsigned carry out of bit WIDTH-1.
  - ovf = carry into MSB XOR carry out of MSB (two's-complement overflow).
- sum during RUN:
  - Partially updated; it is valid only while out_valid=1.
  - Upper slices retain their previous contents until overwritten.
- Reset mid-RUN or mid-DONE: the operation is aborted and the result is lost; the next accepted request computes correctly.

Optional Feature:
- Macro WADD_SUB_EN.
- Defined:
  - sub port exists.
  - When the latched sub=1, every b slice is inverted before the adder, and slice 0 carry-in is forced to 1 (cin ignored).
  - Result = a − b; cout=1 means no borrow; ovf is signed subtract overflow.
- Undefined:
  - No sub port; addition only; no inversion logic synthesized.

Test Plan:
1. WIDTH=64, a=0xFFFF_FFFF_FFFF_FFFF, b=1, cin=0 → out_valid exactly 4 cycles after accept; sum=0, cout=1, ovf=0.
2. a=0x7FFF_FFFF_FFFF_FFFF, b=1, cin=0 → sum=0x8000_0000_0000_0000, cout=0, ovf=1. Also a=0x0000_0000_0000_FFFF, b=1 → sum=0x0000_0000_0001_0000; a=0, b=0, cin=1 → sum=1.
3. Back-pressure: hold out_ready=0 for 10 cycles after out_valid, with in_valid=1 and new operands → out_valid stays 1; sum, cout, ovf stable; in_ready=0; new request ignored. Raise out_ready → out_valid=0 next cycle, in_ready=1, then the new request is accepted.
4. Assert rst 2 cycles into RUN → next cycle out_valid=0, in_ready=1, busy=0, sum=0. Then a=0x1234_5678_9ABC_DEF0, b=0x0FED_CBA9_8765_4321 → sum=0x2222_2222_2222_2211, cout=0.
5. WIDTH=16 instance, a=0x8000, b=0x8000 → out_valid 1 cycle after accept; sum=0x0000, cout=1, ovf=1.
6. With WADD_SUB_EN: a=5, b=7, sub=1 → sum=0xFFFF_FFFF_FFFF_FFFE, cout=0, ovf=0. a=0x8000_0000_0000_0000, b=1, sub=1 → sum=0x7FFF_FFFF_FFFF_FFFF, cout=1, ovf=1.
